// File: rtl/sdf_r2_butterfly.sv
// rtl/sdf_r2_butterfly.sv - radix-2 DIF single-delay-feedback butterfly stage
// Emits N/2 sums then N/2 differences per frame, with a realigned frame counter.
module sdf_r2_butterfly #(
  parameter int DBW = 8,
  parameter int CBW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CBW-1:0]        cnt,
  input  logic signed [DBW-1:0] din_re,
  input  logic signed [DBW-1:0] din_im,
  output logic signed [DBW:0]   dout_re,
  output logic signed [DBW:0]   dout_im,
  output logic [CBW-1:0]        cnt_out,
  output logic                  dout_vld
);

  localparam int W = DBW + 1;
  localparam int D = 1 << (CBW - 1);
  localparam logic [CBW-1:0] CNT_D = CBW'(D);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t state, state_nxt;

  logic [2*W-1:0]     mem [D];
  logic [CBW-2:0]     addr;
  logic               half;
  logic signed [W-1:0] a_re, a_im, b_re, b_im;
  logic signed [W-1:0] res_re, res_im, wr_re, wr_im;
  logic               vld_nxt;

  assign addr = cnt[CBW-2:0];
  assign half = cnt[CBW-1];
  assign b_re = {din_re[DBW-1], din_re};
  assign b_im = {din_im[DBW-1], din_im};
  assign {a_re, a_im} = mem[addr];

  // Second half: emit the sum now, park the difference for the next frame's first half.
  always_comb begin
    res_re = a_re;
    res_im = a_im;
    wr_re  = b_re;
    wr_im  = b_im;
    if (half) begin
      res_re = a_re + b_re;
      res_im = a_im + b_im;
      wr_re  = a_re - b_re;
      wr_im  = a_im - b_im;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    if (cnt == '0)   state_nxt = FILL;
        FILL:    if (cnt == CNT_D) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
    vld_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dout_re  <= '0;
      dout_im  <= '0;
      cnt_out  <= '0;
      dout_vld <= 1'b0;
    end else if (en) begin
      state    <= state_nxt;
      cnt_out  <= {~half, addr};
      dout_vld <= vld_nxt;
      dout_re  <= vld_nxt ? res_re : '0;
      dout_im  <= vld_nxt ? res_im : '0;
    end
  end

  // Delay line is intentionally not reset; FILL rewrites it before any sum is used.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= {wr_re, wr_im};
  end

endmodule

// File: tb/tb_sdf_r2_butterfly.sv
// tb/tb_sdf_r2_butterfly.sv - directed self-checking bench for sdf_r2_butterfly
module tb_sdf_r2_butterfly;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [3:0]        cnt = '0;
  logic signed [7:0] din_re = '0;
  logic signed [7:0] din_im = '0;
  logic signed [8:0] dout_re, dout_im;
  logic [3:0]        cnt_out;
  logic              dout_vld;

  int tests = 0;
  int fails = 0;

  logic [22:0] got, exp_v;
  logic        ev;
  logic [3:0]  ec;
  logic [8:0]  er, ei;

  assign got = {dout_vld, cnt_out, dout_re, dout_im};

  sdf_r2_butterfly #(.DBW(8), .CBW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt(cnt),
    .din_re(din_re), .din_im(din_im),
    .dout_re(dout_re), .dout_im(dout_im),
    .cnt_out(cnt_out), .dout_vld(dout_vld)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (got !== 23'd0) begin
      fails++;
      $display("FAIL reset_initial got=%h exp=%h", got, 23'd0);
    end
    en = 1'b1; cnt = 4'd9; din_re = 8'sd50; din_im = -8'sd50;
    step();
    step();
    tests++;
    if (got !== 23'd0) begin
      fails++;
      $display("FAIL reset_held got=%h exp=%h", got, 23'd0);
    end
  endtask

  task automatic test_ramp();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      en = 1'b1; cnt = 4'(i % 16); din_re = 8'(i % 16); din_im = '0;
      step();
      if (i < 8)       begin ev = 0; ec = 4'(i + 8);  er = 9'd0;          ei = 9'd0; end
      else if (i < 16) begin ev = 1; ec = 4'(i - 8);  er = 9'(2 * i - 8); ei = 9'd0; end
      else             begin ev = 1; ec = 4'(i - 8);  er = 9'(-8);        ei = 9'd0; end
      exp_v = {ev, ec, er, ei};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL ramp i=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      en = 1'b1; cnt = 4'(i % 16);
      if (i < 8)       begin din_re = 8'sh7F; din_im = 8'sh7F; end
      else if (i < 32) begin din_re = 8'sh80; din_im = 8'sh80; end
      else             begin din_re = 8'sh00; din_im = 8'sh00; end
      step();
      ec = 4'(i + 8);
      if (i < 8)       begin ev = 0; er = 9'h000; end
      else if (i < 16) begin ev = 1; er = 9'h1FF; end
      else if (i < 24) begin ev = 1; er = 9'h0FF; end
      else if (i < 32) begin ev = 1; er = 9'h100; end
      else             begin ev = 1; er = 9'h000; end
      exp_v = {ev, ec, er, er};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL extremes i=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      en = 1'b1; cnt = 4'(i % 16); din_re = 8'(i % 16); din_im = '0;
      step();
      if (i < 8)       begin ev = 0; ec = 4'(i + 8);  er = 9'd0;          ei = 9'd0; end
      else if (i < 16) begin ev = 1; ec = 4'(i - 8);  er = 9'(2 * i - 8); ei = 9'd0; end
      else             begin ev = 1; ec = 4'(i - 8);  er = 9'(-8);        ei = 9'd0; end
      exp_v = {ev, ec, er, ei};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL stall_seq i=%0d got=%h exp=%h", i, got, exp_v);
      end
      if (i == 10) begin
        for (int s = 0; s < 3; s++) begin
          en = 1'b0; cnt = 4'd11; din_re = 8'sd99; din_im = 8'sd55;
          step();
          tests++;
          if (got !== exp_v) begin
            fails++;
            $display("FAIL stall_hold s=%0d got=%h exp=%h", s, got, exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_late_start();
    rst = 1'b1; en = 1'b1; cnt = 4'd5;
    step();
    rst = 1'b0;
    for (int i = 5; i < 32; i++) begin
      en = 1'b1; cnt = 4'(i % 16); din_re = 8'(i); din_im = 8'(-(i % 16));
      step();
      if (i < 24) begin ev = 0; ec = 4'(i + 8); er = 9'd0; ei = 9'd0; end
      else begin
        ev = 1; ec = 4'(i - 24);
        er = 9'(2 * (i - 16) + 24);
        ei = 9'(8 - 2 * (i - 16));
      end
      exp_v = {ev, ec, er, ei};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL late_start i=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c <= 12; c++) begin
      en = 1'b1; cnt = 4'(c); din_re = 8'sd7; din_im = 8'sd3;
      step();
      if (c == 0) begin
        exp_v = {1'b1, 4'd8, 9'(-8), 9'd8};
        tests++;
        if (got !== exp_v) begin
          fails++;
          $display("FAIL run_diff got=%h exp=%h", got, exp_v);
        end
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (got !== 23'd0) begin
      fails++;
      $display("FAIL reset_async got=%h exp=%h", got, 23'd0);
    end
    cnt = 4'd13;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 13; i < 32; i++) begin
      en = 1'b1; cnt = 4'(i % 16);
      din_re = 8'(3 * (i % 16) - 20); din_im = 8'(5 - (i % 16));
      if (i != 13) step();
      else begin @(posedge clk); #1; end
      if (i < 24) begin ev = 0; ec = 4'(i + 8); er = 9'd0; ei = 9'd0; end
      else begin
        ev = 1; ec = 4'(i - 24);
        er = 9'(6 * (i - 16) - 64);
        ei = 9'(18 - 2 * (i - 16));
      end
      exp_v = {ev, ec, er, ei};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL reset_mid_run i=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_extremes();
    test_stall();
    test_late_start();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
